// File: rtl/psum_requant_collector_pkg.sv
// Shared widths and saturation bounds for the partial-sum requantizing collector.
package psum_requant_collector_pkg;

    localparam int DEF_PSUM_BW     = 20;
    localparam int DEF_OUT_BW      = 8;
    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_SHIFT_BW    = 5;

    function automatic int sat_max(input int ob);
        return (1 << (ob - 1)) - 1;
    endfunction

    function automatic int sat_min(input int ob);
        return -(1 << (ob - 1));
    endfunction

    localparam int SAT_MAX = sat_max(DEF_OUT_BW);
    localparam int SAT_MIN = sat_min(DEF_OUT_BW);

    typedef struct packed {
        logic full;
        logic sat;
    } vbuf_flags_t;

endpackage

// File: rtl/psum_requant_collector_requant_sat.sv
// Combinational arithmetic right shift with round-half-up, then saturation to OUT_BW.
module requant_sat
    import psum_requant_collector_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = DEF_PSUM_BW,
    parameter int OUT_BW         = DEF_OUT_BW,
    parameter int SHIFT_BW       = DEF_SHIFT_BW
) (
    input  logic signed [PARTIAL_SUM_BW-1:0] x,
    input  logic        [SHIFT_BW-1:0]       s,
    output logic signed [OUT_BW-1:0]         y,
    output logic                             sat
);

    localparam int TW = PARTIAL_SUM_BW + 1;
    localparam logic signed [TW-1:0] HI = TW'(sat_max(OUT_BW));
    localparam logic signed [TW-1:0] LO = TW'(sat_min(OUT_BW));

    logic                 big;
    logic signed [TW-1:0] rnd;
    logic signed [TW-1:0] t;
    logic signed [TW-1:0] sh;

    // Shifts past the input width collapse to the sign of x.
    assign big = 32'(s) >= 32'(PARTIAL_SUM_BW);

    always_comb begin
        rnd = '0;
        if (s != '0 && !big)
            rnd = TW'(1) << (s - 1'b1);
        t = {x[PARTIAL_SUM_BW-1], x} + rnd;
        if (big)
            sh = {TW{x[PARTIAL_SUM_BW-1]}};
        else
            sh = t >>> s;
        sat = 1'b0;
        y   = sh[OUT_BW-1:0];
        if (sh > HI) begin
            y   = HI[OUT_BW-1:0];
            sat = 1'b1;
        end else if (sh < LO) begin
            y   = LO[OUT_BW-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/psum_requant_collector.sv
// Requantizes a stream of row sums and packs MATRIX_SIZE results per vector,
// double-buffered toward a valid/ready consumer.
module psum_requant_collector
    import psum_requant_collector_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = DEF_PSUM_BW,
    parameter int OUT_BW         = DEF_OUT_BW,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int SHIFT_BW       = DEF_SHIFT_BW
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [SHIFT_BW-1:0]           shift_amt,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PARTIAL_SUM_BW-1:0]     in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BW*MATRIX_SIZE-1:0] out_vec,
    output logic                          out_sat
);

    localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    logic [1:0][MATRIX_SIZE-1:0][OUT_BW-1:0] vbuf;
    vbuf_flags_t [1:0]                       flg;
    logic                                    wr_buf;
    logic                                    rd_buf;
    logic [IDX_W-1:0]                        wr_idx;
    logic [SHIFT_BW-1:0]                     shift_q;

    logic                 first;
    logic                 last;
    logic                 accept;
    logic                 drain;
    logic [SHIFT_BW-1:0]  s_eff;
    logic [OUT_BW-1:0]    q_y;
    logic                 q_sat;

    assign first  = (wr_idx == '0);
    assign last   = (wr_idx == IDX_W'(MATRIX_SIZE - 1));
    // Element 0 uses the live shift so the whole vector shares one amount.
    assign s_eff  = first ? shift_amt : shift_q;

    assign in_ready  = !flg[wr_buf].full;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = flg[rd_buf].full;
    assign out_vec   = vbuf[rd_buf];
    assign out_sat   = flg[rd_buf].sat;
    assign drain     = out_valid && out_ready;

    requant_sat #(
        .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
        .OUT_BW         (OUT_BW),
        .SHIFT_BW       (SHIFT_BW)
    ) u_q (
        .x   (in_data),
        .s   (s_eff),
        .y   (q_y),
        .sat (q_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vbuf    <= '0;
            flg     <= '0;
            wr_buf  <= 1'b0;
            rd_buf  <= 1'b0;
            wr_idx  <= '0;
            shift_q <= '0;
        end else begin
            if (flush) begin
                wr_idx <= '0;
            end else if (accept) begin
                vbuf[wr_buf][wr_idx] <= q_y;
                flg[wr_buf].sat      <= q_sat || (flg[wr_buf].sat && !first);
                if (first)
                    shift_q <= shift_amt;
                if (last) begin
                    flg[wr_buf].full <= 1'b1;
                    wr_buf           <= !wr_buf;
                    wr_idx           <= '0;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            // The filling buffer is never the full one being drained.
            if (drain) begin
                flg[rd_buf].full <= 1'b0;
                rd_buf           <= !rd_buf;
            end
        end
    end

endmodule
